segment_mdu: RTL
================

// Module: segment_mdu
// PURPOSE
//   Multi-cycle multiply/divide execution segment sitting beside the ALU in segmentE.
//   Owns the HI/LO registers; accepts one MDU instruction per issue and reports busy.
//   Busy goes to the hazard unit, which stalls any MDU instruction issued while busy.
//   Parametrised successor to the single-cycle E-stage datapath.
// PARAMETERS
//   WIDTH        32  operand width; HI and LO are WIDTH bits each
//   MULT_CYCLES  5   cycles from accepted mult/multu until HI/LO update (>=1)
//   DIV_CYCLES   10  cycles from accepted div/divu until HI/LO update (>=1)
// PORTS
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous, active-low; clears all state
//   istart       in   1      issue strobe, sampled at rising edge
//   iop          in   3      0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 see CONFIGURATION
//   iA           in   WIDTH  rs operand (forwarded)
//   iB           in   WIDTH  rt operand (forwarded)
//   oHI          out  WIDTH  HI register
//   oLO          out  WIDTH  LO register
//   obusy        out  1      registered; high while an operation is in flight
//   ostall_req   out  1      combinational: obusy | (istart & iop<=3); drives the hazard unit
// BEHAVIOUR
//   - Reset (reset==0, any time): oHI=0, oLO=0, obusy=0, counter=0, pending op discarded.
//   - FSM states IDLE, RUN.
//     - IDLE: istart & op in {mult,multu,div,divu} -> latch iA/iB/op; load counter with
//       MULT_CYCLES or DIV_CYCLES; go RUN; obusy=1 from next cycle.
//     - RUN: counter decrements each edge; on the edge where it reaches 0, HI/LO written,
//       obusy falls, state returns to IDLE. HI/LO valid at edge N after the issue edge.
//     - RUN: istart of any op ignored (hazard unit guarantees none; bench checks ignore).
//   - mthi/mtlo (IDLE only): write oHI/oLO = iA at the issue edge; obusy stays 0.
//   - HI/LO never change other than at completion, mthi/mtlo, or reset.
//   - mult: signed WIDTHxWIDTH -> 2*WIDTH product; HI = upper half, LO = lower half.
//     multu: same, unsigned.
//   - div: signed; LO = quotient truncated toward zero; HI = remainder, sign of dividend.
//     divu: unsigned.
//   - div/divu with iB==0: op still takes DIV_CYCLES and asserts busy; HI/LO unchanged.
//   - div of MIN_INT by -1: LO = MIN_INT (0x80000000), HI = 0; no trap.
//   - Completion edge with istart of a new op: new op not accepted (busy still 1 that edge);
//     accepted the following cycle.
//   - Operands latched at issue; later iA/iB changes have no effect on the result.
//   - iop 6/7 without the macro: treated as no-op; no state change.
// CONFIGURATION
//   MDU_MADD_EN defined:
//     iop 6 = madd, 7 = msub (signed); {HI,LO} <= {HI,LO} +/- iA*iB.
//     Latency MULT_CYCLES; {HI,LO} sampled at the completion edge.
//     Wraps modulo 2^(2*WIDTH).
//     ostall_req also covers iop 6/7.
//   MDU_MADD_EN undefined:
//     iop 6/7 ignored as above; no accumulate hardware instantiated.
// TESTING
//   - reset=0 mid-div at counter=4 -> next sample: obusy=0, oHI=0, oLO=0; IDLE; new mult accepted.
//   - mult iA=0xFFFFFFFF, iB=2 -> obusy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
//     multu, same operands -> HI=0x00000001, LO=0xFFFFFFFE.
//   - div iA=-7, iB=2 -> after 10 cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
//     divu 7/0 -> busy 10 cycles, HI/LO unchanged.
//   - mthi iA=0x1234 while idle -> oHI=0x1234 next edge, obusy stays 0.
//     mtlo issued during RUN -> ignored, oLO keeps old value.
//   - istart=1 with mult on the completion edge -> not accepted.
//     Re-issue next cycle -> accepted; back-to-back results correct.
//   - MDU_MADD_EN: HI:LO=0:5, madd 3*4 -> 0:17 (0x11); msub 0*1 -> unchanged; without macro iop6 no-op.

Source files
------------

// File: rtl/segment_mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO, with busy/stall reporting.
// Optional accumulate ops (madd/msub on iop 6/7) are enabled by defining MDU_MADD_EN.
module segment_mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             istart,
  input  logic [2:0]       iop,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic [WIDTH-1:0] oHI,
  output logic [WIDTH-1:0] oLO,
  output logic             obusy,
  output logic             ostall_req
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  // Low 2*WIDTH bits of a product of sign-extended operands equal the signed product.
  logic [2*WIDTH-1:0] a_sx, b_sx, prod_s, prod_u;
  assign a_sx   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign b_sx   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  // One unsigned divider on magnitudes; signs are reapplied afterwards.
  logic             div_signed, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] dvd, dvs, q_mag, r_mag, q_res, r_res;
  assign div_signed = (op_q == OP_DIV);
  assign a_neg      = div_signed & a_q[WIDTH-1];
  assign b_neg      = div_signed & b_q[WIDTH-1];
  assign b_zero     = (b_q == '0);
  assign dvd        = a_neg ? (~a_q + 1'b1) : a_q;
  assign dvs        = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : (b_neg ? (~b_q + 1'b1) : b_q);
  assign q_mag      = dvd / dvs;
  assign r_mag      = dvd % dvs;
  assign q_res      = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
  assign r_res      = a_neg ? (~r_mag + 1'b1) : r_mag;

`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] acc_res;
  assign acc_res = (op_q == OP_MSUB) ? ({hi_q, lo_q} - prod_s) : ({hi_q, lo_q} + prod_s);
  assign ostall_req = obusy | (istart & ((iop <= OP_DIVU) | (iop >= OP_MADD)));
`else
  assign ostall_req = obusy | (istart & (iop <= OP_DIVU));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == S_IDLE) begin
      if (istart) begin
        case (iop)
          OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
            op_d    = iop;
            a_d     = iA;
            b_d     = iB;
            cnt_d   = iop[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state_d = S_RUN;
          end
          OP_MTHI: hi_d = iA;
          OP_MTLO: lo_d = iA;
`ifdef MDU_MADD_EN
          OP_MADD, OP_MSUB: begin
            op_d    = iop;
            a_d     = iA;
            b_d     = iB;
            cnt_d   = CW'(MULT_CYCLES);
            state_d = S_RUN;
          end
`endif
          default: ;
        endcase
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = S_IDLE;
        case (op_q)
          OP_MULT:  {hi_d, lo_d} = prod_s;
          OP_MULTU: {hi_d, lo_d} = prod_u;
          OP_DIV, OP_DIVU: begin
            if (!b_zero) begin
              hi_d = r_res;
              lo_d = q_res;
            end
          end
`ifdef MDU_MADD_EN
          OP_MADD, OP_MSUB: {hi_d, lo_d} = acc_res;
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign obusy = (state_q == S_RUN);
  assign oHI   = hi_q;
  assign oLO   = lo_q;

endmodule
